irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single CPU clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port irq_src, input, 4 bits: asynchronous interrupt sources (0 timer, 1 UART RX, 2 UART TX, 3 external).
REQ-004 The block SHALL have ports cfg_we (input, 1), cfg_addr (input, 2) and cfg_wdata (input, 32): the register write port.
REQ-005 The block SHALL have port cfg_rdata, output, 32 bits: combinational readback at cfg_addr.
REQ-006 The block SHALL have port kernel, input, 1 bit: PC[31] of the ID-stage instruction.
REQ-007 The block SHALL have port pipe_hold, input, 1 bit: the hazard unit is stalling or flushing IF/ID.
REQ-008 The block SHALL have port id_is_branch, input, 1 bit: the ID stage holds a branch, jump, jr or jalr.
REQ-009 The block SHALL have port id_is_eret, input, 1 bit: the ID stage holds the return-from-interrupt instruction (jr $26 in kernel).
REQ-010 The block SHALL have port irq, output, 1 bit: drives the IRQ input of Control.
REQ-011 The block SHALL have port irq_cause, output, 2 bits: index of the source being serviced.
REQ-012 The block SHALL have port irq_busy, output, 1 bit: a handler is in progress.

Function
REQ-013 irq_src SHALL pass through a two-flop synchroniser (s1, s2); rise = s2 & ~s3, where s3 is a third delay flop.
REQ-014 PEND[i] SHALL be set by rise[i] and cleared by a cfg write of 1 to bit i at addr 1; if set and clear occur in the same cycle, set wins.
REQ-015 Registers SHALL be: addr 0 MASK[3:0] RW; addr 1 PEND[3:0] read/W1C; addr 2 CTRL bit0 GIE RW; addr 3 STATUS read-only {busy at bit 4, cause at bits 1:0}; unused bits read 0.
REQ-016 eligible SHALL equal PEND & MASK & {4{GIE}}.
REQ-017 The FSM SHALL have states IDLE, ARM, TAKE, SERVICE and DRAIN.
REQ-018 IDLE SHALL go to ARM when eligible != 0 and kernel == 0.
REQ-019 ARM SHALL go to TAKE when pipe_hold == 0 and id_is_branch == 0, latching the selected index into irq_cause; ARM SHALL go to IDLE, with no irq, if eligible becomes 0.
REQ-020 irq SHALL be 1 only in TAKE; TAKE SHALL last exactly one cycle and then go to SERVICE.
REQ-021 irq_busy SHALL be 1 in TAKE, SERVICE and DRAIN.
REQ-022 SERVICE SHALL go to DRAIN on id_is_eret & ~pipe_hold.
REQ-023 DRAIN SHALL last 2 cycles, for eret to clear EX/MEM, then return to IDLE.
REQ-024 New rises during SERVICE or DRAIN SHALL only set PEND; no nesting.
REQ-025 Minimum latency SHALL be: irq_src rise sampled at edge k gives irq high in the cycle after edge k+4 (sync 2, pend 1, ARM 1, TAKE 1).
REQ-026 A cfg write to MASK or GIE that removes the last eligible bit while in ARM SHALL cancel the request in the same cycle.

Reset
REQ-027 While reset = 1 at a clk edge: state IDLE; MASK, PEND, GIE, s1 to s3 and irq_cause = 0; irq = 0 and irq_busy = 0 from the next cycle.
REQ-028 Reset SHALL abort any state, including TAKE and SERVICE, without emitting irq.
REQ-029 Sources already high at reset release SHALL NOT produce a rise, because s3 fills from s2.

Configuration
REQ-030 With IRQ_ROUND_ROBIN_EN defined, selection SHALL be round-robin: search starts at (last serviced index + 1) mod 4, last index resets to 3.
REQ-031 Without IRQ_ROUND_ROBIN_EN, selection SHALL be fixed priority, lowest index wins.

Verification
REQ-032 MASK=4'hF, GIE=1, irq_src[1] rises, hold=0, branch=0 -> irq one cycle at rise+5, irq_cause=1, STATUS=5'h11.
REQ-033 Pending source 0, id_is_branch=1 for 3 cycles, then 0 -> state ARM throughout, irq exactly 1 cycle after branch drops.
REQ-034 In SERVICE, raise src 2, then id_is_eret -> PEND=4'b0100, DRAIN 2 cycles, IDLE, second irq with cause 2 (W1C the first bit beforehand).
REQ-035 Sources 0 and 3 pending together, serviced twice -> fixed: 0, 0 (0 not cleared) or 0, 3 after W1C; RR: 0, then 3 with 0 still pending.
REQ-036 Write W1C of bit 2 in the same cycle as rise[2] -> PEND[2]=1.
REQ-037 Assert reset during SERVICE -> next cycle irq=0, irq_busy=0, cfg_rdata=0 for all addresses.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source interrupt controller driving the IRQ input of Control.
// Define IRQ_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  irq_src,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   input  logic        kernel,
   input  logic        pipe_hold,
   input  logic        id_is_branch,
   input  logic        id_is_eret,
   output logic        irq,
   output logic [1:0]  irq_cause,
   output logic        irq_busy
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      TAKE,
      SERVICE,
      DRAIN
   } state_t;

   state_t     state, state_n;
   logic [3:0] s1, s2, s3;
   logic [1:0] warm;
   logic [3:0] rise;
   logic [3:0] mask, mask_n;
   logic [3:0] pend, pend_n;
   logic       gie, gie_n;
   logic [3:0] eligible, elig_arm;
   logic [1:0] sel;
   logic       take;
   logic       drain_cnt;
   logic       wr_mask, wr_pend, wr_ctrl;
   logic       unused_wdata;

   assign unused_wdata = ^cfg_wdata[31:4];

   assign wr_mask = cfg_we && (cfg_addr == 2'd0);
   assign wr_pend = cfg_we && (cfg_addr == 2'd1);
   assign wr_ctrl = cfg_we && (cfg_addr == 2'd2);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         s3   <= '0;
         warm <= '0;
      end else begin
         s1 <= irq_src;
         s2 <= s1;
         s3 <= s2;
         if (warm != 2'd3)
            warm <= warm + 2'd1;
      end
   end

   // Edges are ignored until s3 holds real post-reset data, so levels
   // already present at reset release never look like a rise.
   assign rise = (warm == 2'd3) ? (s2 & ~s3) : 4'd0;

   always_comb begin
      mask_n = wr_mask ? cfg_wdata[3:0] : mask;
      gie_n  = wr_ctrl ? cfg_wdata[0] : gie;
      pend_n = (pend & ~(wr_pend ? cfg_wdata[3:0] : 4'd0)) | rise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask <= '0;
         pend <= '0;
         gie  <= 1'b0;
      end else begin
         mask <= mask_n;
         pend <= pend_n;
         gie  <= gie_n;
      end
   end

   assign eligible = pend & mask & {4{gie}};
   // A MASK/GIE write in flight withdraws the request in the same cycle.
   assign elig_arm = eligible & mask_n & {4{gie_n}};

`ifdef IRQ_ROUND_ROBIN_EN
   logic [1:0] last;
   logic [1:0] idx;

   always_comb begin
      sel = 2'd0;
      idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = last + 2'd1 + 2'(k);
         if (elig_arm[idx])
            sel = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         last <= 2'd3;
      else if (take)
         last <= sel;
   end
`else
   always_comb begin
      sel = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (elig_arm[k])
            sel = 2'(k);
      end
   end
`endif

   always_comb begin
      state_n = state;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            if ((eligible != 4'd0) && !kernel)
               state_n = ARM;
         end
         ARM: begin
            if (elig_arm == 4'd0) begin
               state_n = IDLE;
            end else if (!pipe_hold && !id_is_branch) begin
               state_n = TAKE;
               take    = 1'b1;
            end
         end
         TAKE:    state_n = SERVICE;
         SERVICE: begin
            if (id_is_eret && !pipe_hold)
               state_n = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         irq_cause <= 2'd0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_n;
         drain_cnt <= (state == DRAIN) && !drain_cnt;
         if (take)
            irq_cause <= sel;
      end
   end

   assign irq      = (state == TAKE);
   assign irq_busy = (state == TAKE) || (state == SERVICE) ||
                     (state == DRAIN);

   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_addr)
         2'd0: cfg_rdata[3:0] = mask;
         2'd1: cfg_rdata[3:0] = pend;
         2'd2: cfg_rdata[0]   = gie;
         2'd3: begin
            cfg_rdata[4]   = irq_busy;
            cfg_rdata[1:0] = irq_cause;
         end
         default: cfg_rdata = '0;
      endcase
   end

endmodule
